// File: rtl/sub_bytes_arbiter_if.sv
// rtl/sub_bytes_arbiter_if.sv - handshake bundle between the two S-box requesters and the shared arbiter
interface sub_bytes_arbiter_if;
  logic         keyReq;
  logic [31:0]  keyWordIn;
  logic         keyAck;
  logic [31:0]  keyWordOut;
  logic         keyValid;
  logic         stateReq;
  logic [127:0] stateIn;
  logic         stateAck;
  logic [127:0] stateOut;
  logic         stateValid;
  logic         busy;

  modport slave (
    input  keyReq, keyWordIn, stateReq, stateIn,
    output keyAck, keyWordOut, keyValid, stateAck, stateOut, stateValid, busy
  );

  modport master (
    output keyReq, keyWordIn, stateReq, stateIn,
    input  keyAck, keyWordOut, keyValid, stateAck, stateOut, stateValid, busy
  );
endinterface

// File: rtl/sub_bytes_arbiter.sv
// rtl/sub_bytes_arbiter.sv - four shared AES s_box lanes arbitrated between key expansion and SubBytes
// Optional: SUB_BYTES_ARBITER_ROUND_ROBIN_EN alternates grants on simultaneous requests.
module sub_bytes_arbiter (
  input  logic                 clk,
  input  logic                 reset,
  sub_bytes_arbiter_if.slave   bus
);
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_KEY   = 2'd1;
  localparam logic [1:0] ST_STATE = 2'd2;

  logic [1:0]   state_q, state_d;
  logic [1:0]   col_q, col_d;
  logic [31:0]  key_word_q, key_word_d;
  logic [127:0] state_lat_q, state_lat_d;
  logic [127:0] buf_q, buf_d;
  logic [31:0]  key_out_q, key_out_d;
  logic [127:0] state_out_q, state_out_d;
  logic         key_ack_q, key_ack_d;
  logic         key_valid_q, key_valid_d;
  logic         state_ack_q, state_ack_d;
  logic         state_valid_q, state_valid_d;
  logic         busy_q, busy_d;
  logic         pick_key;
  logic [31:0]  lane_word;
  logic [31:0]  sub_word;

`ifdef SUB_BYTES_ARBITER_ROUND_ROBIN_EN
  // rr_q set means the state requester has priority on the next tie
  logic rr_q, rr_d;
  assign pick_key = bus.keyReq && (!bus.stateReq || !rr_q);
`else
  assign pick_key = bus.keyReq;
`endif

  assign lane_word = (state_q == ST_STATE) ? state_lat_q[{~col_q, 5'b00000} +: 32] : key_word_q;

  for (genvar i = 0; i < 4; i++) begin : g_lane
    s_box u_s_box (.in_byte(lane_word[8*i +: 8]), .out_byte(sub_word[8*i +: 8]));
  end

  always_comb begin
    state_d       = state_q;
    col_d         = col_q;
    key_word_d    = key_word_q;
    state_lat_d   = state_lat_q;
    buf_d         = buf_q;
    key_out_d     = key_out_q;
    state_out_d   = state_out_q;
    key_ack_d     = 1'b0;
    key_valid_d   = 1'b0;
    state_ack_d   = 1'b0;
    state_valid_d = 1'b0;
`ifdef SUB_BYTES_ARBITER_ROUND_ROBIN_EN
    rr_d          = rr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pick_key) begin
          key_word_d = bus.keyWordIn;
          key_ack_d  = 1'b1;
          state_d    = ST_KEY;
`ifdef SUB_BYTES_ARBITER_ROUND_ROBIN_EN
          rr_d       = ~rr_q;
`endif
        end else if (bus.stateReq) begin
          state_lat_d = bus.stateIn;
          state_ack_d = 1'b1;
          col_d       = 2'd0;
          state_d     = ST_STATE;
`ifdef SUB_BYTES_ARBITER_ROUND_ROBIN_EN
          rr_d        = ~rr_q;
`endif
        end
      end
      ST_KEY: begin
        key_out_d   = sub_word;
        key_valid_d = 1'b1;
        state_d     = ST_IDLE;
      end
      ST_STATE: begin
        buf_d[{~col_q, 5'b00000} +: 32] = sub_word;
        col_d = col_q + 2'd1;
        // Last column goes straight to the output so no partial state is ever visible
        if (col_q == 2'd3) begin
          state_out_d   = {buf_q[127:32], sub_word};
          state_valid_d = 1'b1;
          state_d       = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      col_q         <= 2'd0;
      key_word_q    <= '0;
      state_lat_q   <= '0;
      buf_q         <= '0;
      key_out_q     <= '0;
      state_out_q   <= '0;
      key_ack_q     <= 1'b0;
      key_valid_q   <= 1'b0;
      state_ack_q   <= 1'b0;
      state_valid_q <= 1'b0;
      busy_q        <= 1'b0;
`ifdef SUB_BYTES_ARBITER_ROUND_ROBIN_EN
      rr_q          <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      col_q         <= col_d;
      key_word_q    <= key_word_d;
      state_lat_q   <= state_lat_d;
      buf_q         <= buf_d;
      key_out_q     <= key_out_d;
      state_out_q   <= state_out_d;
      key_ack_q     <= key_ack_d;
      key_valid_q   <= key_valid_d;
      state_ack_q   <= state_ack_d;
      state_valid_q <= state_valid_d;
      busy_q        <= busy_d;
`ifdef SUB_BYTES_ARBITER_ROUND_ROBIN_EN
      rr_q          <= rr_d;
`endif
    end
  end

  assign bus.keyAck     = key_ack_q;
  assign bus.keyWordOut = key_out_q;
  assign bus.keyValid   = key_valid_q;
  assign bus.stateAck   = state_ack_q;
  assign bus.stateOut   = state_out_q;
  assign bus.stateValid = state_valid_q;
  assign bus.busy       = busy_q;
endmodule

// AES forward S-box lane; table entry 0x00 sits in the most significant byte.
module s_box (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
  assign out_byte = SBOX[{~in_byte, 3'b000} +: 8];
endmodule

// File: tb/tb_sub_bytes_arbiter.sv
// tb/tb_sub_bytes_arbiter.sv - directed vector bench for sub_bytes_arbiter
module tb_sub_bytes_arbiter;
  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail = 0;

  sub_bytes_arbiter_if bus();
  sub_bytes_arbiter dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic         is_key;
    logic [127:0] din;
    logic [127:0] exp;
  } vec_t;
  vec_t vecs[8];

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", nm, act, exp);
    end
  endtask

  // Raise one request, wait for ack, drop it, then follow the job to its valid pulse.
  task automatic do_job(input logic is_key, input logic [127:0] din, input logic [127:0] exp,
                        input string nm, output int ack_wait);
    logic got;
    int lat;
    logic [127:0] old_state;
    if (is_key) begin bus.keyReq = 1'b1; bus.keyWordIn = din[31:0]; end
    else begin bus.stateReq = 1'b1; bus.stateIn = din; end
    got = 1'b0;
    ack_wait = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk); #1;
      ack_wait++;
      if (is_key ? bus.keyAck : bus.stateAck) got = 1'b1;
    end
    check({nm, " ack"}, {127'b0, got}, 128'd1);
    bus.keyReq = 1'b0;
    bus.stateReq = 1'b0;
    old_state = bus.stateOut;
    got = 1'b0;
    lat = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(posedge clk); #1;
      lat++;
      if (is_key ? bus.keyValid : bus.stateValid) got = 1'b1;
      else begin
        check({nm, " busy"}, {127'b0, bus.busy}, 128'd1);
        if (!is_key) check({nm, " no partial"}, bus.stateOut, old_state);
      end
    end
    check({nm, " latency"}, lat, is_key ? 128'd1 : 128'd4);
    check({nm, " busy after"}, {127'b0, bus.busy}, 128'd0);
    check({nm, " data"}, is_key ? {96'b0, bus.keyWordOut} : bus.stateOut, exp);
  endtask

  task automatic wait_ack(output logic k, output logic s);
    k = 1'b0; s = 1'b0;
    for (int i = 0; i < 20 && !(k || s); i++) begin
      @(posedge clk); #1;
      k = bus.keyAck; s = bus.stateAck;
    end
  endtask

  task automatic wait_valid(input logic is_key, output int lat);
    logic got = 1'b0;
    lat = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(posedge clk); #1;
      lat++;
      got = is_key ? bus.keyValid : bus.stateValid;
    end
    if (!got) lat = -1;
  endtask

  initial begin
    int w;
    logic k, s;
    logic [31:0] kw_before;

    vecs[0] = '{1'b1, 128'h0077DD53, 128'h63F5C1ED};
    vecs[1] = '{1'b0, 128'h0, {16{8'h63}}};
    vecs[2] = '{1'b1, 128'h00000000, 128'h63636363};
    vecs[3] = '{1'b1, 128'hFFFFFFFF, 128'h16161616};
    vecs[4] = '{1'b1, 128'h01020304, 128'h7C777BF2};
    vecs[5] = '{1'b1, 128'h10203040, 128'hCAB70409};
    vecs[6] = '{1'b0, 128'h000102030405060708090A0B0C0D0E0F,
                      128'h637C777BF26B6FC53001672BFED7AB76};
    vecs[7] = '{1'b0, 128'hFFFFFFFF000000000077DD5301020304,
                      128'h161616166363636363F5C1ED7C777BF2};

    reset = 1'b1;
    bus.keyReq = 1'b0; bus.keyWordIn = '0; bus.stateReq = 1'b0; bus.stateIn = '0;
    @(posedge clk); @(posedge clk); #1;
    check("reset outs", {bus.keyAck, bus.keyValid, bus.stateAck, bus.stateValid, bus.busy}, 128'd0);
    check("reset keyWordOut", {96'b0, bus.keyWordOut}, 128'd0);
    check("reset stateOut", bus.stateOut, 128'd0);
    @(negedge clk); reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      do_job(vecs[i].is_key, vecs[i].din, vecs[i].exp, $sformatf("vec%0d", i), w);
    end

    // Request withdrawn before any edge sees it
    @(posedge clk); #1;
    kw_before = bus.keyWordOut;
    bus.keyReq = 1'b1; bus.keyWordIn = 32'h12345678;
    #3 bus.keyReq = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("dropped req quiet", {bus.keyAck, bus.keyValid, bus.busy}, 128'd0);
    end
    check("dropped req data", {96'b0, bus.keyWordOut}, {96'b0, kw_before});

    // Simultaneous requests twice
    bus.keyReq = 1'b1; bus.keyWordIn = 32'h0077DD53;
    bus.stateReq = 1'b1; bus.stateIn = '0;
    wait_ack(k, s);
    check("tie1 grant", {k, s}, 128'b10);
    bus.keyReq = 1'b0;
    wait_valid(1'b1, w);
    check("tie1 key latency", w, 128'd1);
    bus.keyReq = 1'b1; bus.keyWordIn = 32'hFFFFFFFF;
    wait_ack(k, s);
`ifdef SUB_BYTES_ARBITER_ROUND_ROBIN_EN
    check("tie2 grant", {k, s}, 128'b01);
    bus.stateReq = 1'b0;
    wait_valid(1'b0, w);
    wait_ack(k, s);
    check("tie2 follow", {k, s}, 128'b10);
    bus.keyReq = 1'b0;
    wait_valid(1'b1, w);
    check("tie2 key out", {96'b0, bus.keyWordOut}, 128'h16161616);
`else
    check("tie2 grant", {k, s}, 128'b10);
    bus.keyReq = 1'b0;
    wait_valid(1'b1, w);
    check("tie2 key out", {96'b0, bus.keyWordOut}, 128'h16161616);
    wait_ack(k, s);
    check("tie2 follow", {k, s}, 128'b01);
    bus.stateReq = 1'b0;
    wait_valid(1'b0, w);
`endif
    check("tie state out", bus.stateOut, {16{8'h63}});

    // Key request during a state job must wait
    bus.stateReq = 1'b1; bus.stateIn = vecs[6].din;
    wait_ack(k, s);
    check("noprempt state grant", {k, s}, 128'b01);
    bus.stateReq = 1'b0;
    bus.keyReq = 1'b1; bus.keyWordIn = 32'h01020304;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("noprempt no keyAck", {127'b0, bus.keyAck}, 128'd0);
    end
    check("noprempt stateValid", {127'b0, bus.stateValid}, 128'd1);
    @(posedge clk); #1;
    check("noprempt keyAck next", {127'b0, bus.keyAck}, 128'd1);
    bus.keyReq = 1'b0;
    wait_valid(1'b1, w);
    check("noprempt key out", {96'b0, bus.keyWordOut}, 128'h7C777BF2);

    // Reset in the middle of a state job at col=2
    bus.stateReq = 1'b1; bus.stateIn = vecs[7].din;
    wait_ack(k, s);
    check("rst job grant", {k, s}, 128'b01);
    bus.stateReq = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check("rst immediate outs", {bus.keyAck, bus.keyValid, bus.stateAck, bus.stateValid, bus.busy}, 128'd0);
    check("rst immediate stateOut", bus.stateOut, 128'd0);
    check("rst immediate keyWordOut", {96'b0, bus.keyWordOut}, 128'd0);
    bus.stateReq = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("rst no valid", {bus.stateValid, bus.busy}, 128'd0);
    end
    @(negedge clk); reset = 1'b0;
    bus.stateReq = 1'b0;
    do_job(1'b0, vecs[7].din, vecs[7].exp, "post reset", w);
    check("post reset first edge grant", w, 128'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/sub_bytes_arbiter.md
SUB_BYTES_ARBITER -- requirements
Module: sub_bytes_arbiter

Interface
REQ-001 The block SHALL have no parameters; it SHALL instantiate exactly four s_box lanes internally, shared by two requesters.
REQ-002 clk  input  1  the block's one clock; all state changes on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 keyReq  input  1  key-expansion requester asks for a SubWord; level, held until keyAck.
REQ-005 keyWordIn  input  32  word to substitute; sampled on the grant edge.
REQ-006 keyAck  output  1  one-cycle registered pulse: key request granted and word latched.
REQ-007 keyWordOut  output  32  substituted word; held until the next key job completes.
REQ-008 keyValid  output  1  one-cycle registered pulse: keyWordOut is updated.
REQ-009 stateReq  input  1  round datapath asks for SubBytes on the full state; level, held until stateAck.
REQ-010 stateIn  input  128  state to substitute; sampled on the grant edge.
REQ-011 stateAck  output  1  one-cycle registered pulse: state request granted and state latched.
REQ-012 stateOut  output  128  substituted state; held until the next state job completes.
REQ-013 stateValid  output  1  one-cycle registered pulse: stateOut is updated.
REQ-014 busy  output  1  high whenever the FSM is not IDLE.

Function
REQ-015 FSM states SHALL be IDLE, KEY and STATE; all outputs SHALL be registered.
REQ-016 IDLE grant edge: latch the chosen input, pulse that requester's ack next cycle, and enter KEY or STATE (state entry also sets col=0).
REQ-017 KEY: on the next edge, keyWordOut SHALL take the byte-wise s_box of the latched word, keyValid SHALL pulse, and the FSM SHALL return to IDLE; keyValid is high one cycle after keyAck.
REQ-018 STATE: each edge SHALL substitute column col, which is latched bits [127-32*col -: 32], through the four lanes into an internal buffer, then increment col.
REQ-019 When col=3 is processed, stateOut SHALL load the full buffer, stateValid SHALL pulse, and the FSM SHALL return to IDLE; stateValid is high four cycles after stateAck.
REQ-020 stateOut SHALL never expose a partially substituted state.
REQ-021 A running job SHALL NOT be preempted; requests arriving while busy SHALL wait and be served from IDLE.
REQ-022 A requester SHALL drop its req in the cycle its ack is seen; a req still high in IDLE after completion SHALL be treated as a new job.
REQ-023 A req that falls before its ack SHALL be dropped with no outputs changed.
REQ-024 The col counter is 2 bits and SHALL wrap 3 to 0 only on exit from STATE.

Reset
REQ-025 Reset SHALL immediately force IDLE, col=0, all ack/valid/busy low, and keyWordOut, stateOut and internal latches to zero.
REQ-026 Reset mid-job SHALL abort the job with no valid pulse; the first grant after reset release SHALL be on the first rising edge with reset low.

Configuration
REQ-027 Macro SUB_BYTES_ARBITER_ROUND_ROBIN_EN: when defined, simultaneous requests in IDLE SHALL be granted alternately, starting with key after reset and toggling after each grant.
REQ-028 When the macro is undefined, key SHALL always win simultaneous requests (fixed priority).

Verification
REQ-029 keyReq with keyWordIn=0x0077DD53 -> keyAck pulse, then keyValid next cycle with keyWordOut=0x63F5C1ED, busy high for 1 cycle.
REQ-030 stateReq with stateIn=all 0x00 -> stateAck, stateValid 4 cycles later, stateOut=all 0x63, busy high for 4 cycles.
REQ-031 keyReq and stateReq both high from IDLE, macro undefined, twice -> both grants go to key first each time; with macro defined -> grants are key, then state, then key.
REQ-032 keyReq raised during a state job -> no grant until stateValid; keyAck arrives in the cycle after return to IDLE.
REQ-033 reset asserted at col=2 -> outputs zero immediately, no stateValid; a re-request after release completes normally.
